shift_exec_stage: RTL and testbench

//  Execute-stage shift unit. Accepts decoded shift ops from ID/EX, maps them onto
//  the 4-op barrel `shifter` (ROL/SLL/SRA/SRL), adds ROR, and hands registered

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_exec_stage_shifter.sv | 25 ++
 rtl/shift_exec_stage.sv | 144 ++++++++++++++
 tb/tb_shift_exec_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Purpose: shared op codes, shifter op codes, result entry type and skid FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

    localparam int SH_N  = 16;
    localparam int SH_RW = 3;

    // Decoded shift op codes arriving from ID/EX
    localparam logic [2:0] SH_ROL = 3'd0;
    localparam logic [2:0] SH_SLL = 3'd1;
    localparam logic [2:0] SH_ROR = 3'd2;
    localparam logic [2:0] SH_SRL = 3'd3;
    localparam logic [2:0] SH_SRA = 3'd4;

    // Op codes understood by the barrel shifter
    localparam logic [1:0] SHF_ROL = 2'b00;
    localparam logic [1:0] SHF_SLL = 2'b01;
    localparam logic [1:0] SHF_SRA = 2'b10;
    localparam logic [1:0] SHF_SRL = 2'b11;

    typedef struct packed {
        logic [SH_N-1:0]  data;
        logic [SH_RW-1:0] rd;
        logic             zero;
        logic             err;
    } sh_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sh_state_t;

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// Purpose: 16-bit barrel shifter supporting ROL, SLL, SRA and SRL.
// Latency: purely combinational.
// Backpressure: none; no handshake at this level.
import shift_pkg::*;

module shifter (
    input  logic [15:0] A,
    input  logic [1:0]  Op,
    input  logic [3:0]  Cnt,
    output logic [15:0] Y
);

    // Select the shift flavour; a rotate by 0 falls out as A because A>>16 is 0
    always_comb begin
        Y = A;
        case (Op)
            SHF_ROL: Y = (A << Cnt) | (A >> (5'd16 - {1'b0, Cnt}));
            SHF_SLL: Y = A << Cnt;
            SHF_SRA: Y = $signed(A) >>> Cnt;
            SHF_SRL: Y = A >> Cnt;
            default: Y = A;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Purpose: execute-stage shift unit (ROL/SLL/ROR/SRL/SRA) feeding EX/MEM.
// Latency: 1 cycle from accept to out_valid; sustains 1 op/cycle.
// Backpressure: 2-entry skid buffer; in_ready is a registered function of FSM state.
import shift_pkg::*;

module shift_exec_stage #(
    parameter int N  = SH_N,
    parameter int RW = SH_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [N-1:0]  in_a,
    input  logic [3:0]    in_cnt,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_zero,
    output logic          out_err
);

    localparam sh_entry_t ENTRY_RST = '{data: '0, rd: '0, zero: 1'b1, err: 1'b0};

    sh_state_t  state, nextState;
    sh_entry_t  mainReg, skidReg, newEntry;
    logic [1:0] shOp;
    logic [3:0] shCnt;
    logic [N-1:0] shY;
    logic       illegal;
    logic       accept, emit;
    logic       loadMain, loadSkid, moveSkid;

    // Map the decoded op onto the shifter; ROR becomes ROL by (16 - cnt) mod 16
    always_comb begin
        shOp    = SHF_ROL;
        shCnt   = in_cnt;
        illegal = 1'b0;
        case (in_op)
            SH_ROL: shOp = SHF_ROL;
            SH_SLL: shOp = SHF_SLL;
            SH_ROR: begin
                shOp  = SHF_ROL;
                shCnt = 4'd0 - in_cnt;
            end
            SH_SRL: shOp = SHF_SRL;
            SH_SRA: shOp = SHF_SRA;
            default: illegal = 1'b1;
        endcase
    end

    shifter uShifter (
        .A   (in_a),
        .Op  (shOp),
        .Cnt (shCnt),
        .Y   (shY)
    );

    // Build the entry to store; zero/err flags are computed here so the outputs stay pure registers
    always_comb begin
        newEntry.data = illegal ? '0 : shY;
        newEntry.rd   = in_rd;
        newEntry.zero = (newEntry.data == '0);
        newEntry.err  = illegal;
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Skid FSM next state and register load controls; flush overrides any transfer
    always_comb begin
        nextState = state;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        moveSkid  = 1'b0;
        if (flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        loadMain  = 1'b1;
                        nextState = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        loadMain = 1'b1;
                    end else if (accept) begin
                        loadSkid  = 1'b1;
                        nextState = FULL;
                    end else if (emit) begin
                        nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        moveSkid  = 1'b1;
                        nextState = ONE;
                    end
                end
                default: nextState = EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Main and skid data registers; both hold while stalled so outputs never change under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainReg <= ENTRY_RST;
            skidReg <= ENTRY_RST;
        end else begin
            if (loadMain) begin
                mainReg <= newEntry;
            end else if (moveSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= newEntry;
            end
        end
    end

    assign out_data = mainReg.data;
    assign out_rd   = mainReg.rd;
    assign out_zero = mainReg.zero;
    assign out_err  = mainReg.err;

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
    logic [2:0]  in_op, in_rd, out_rd;
    logic [15:0] in_a, out_data;
    logic [3:0]  in_cnt;

    always #5 clk = ~clk;

    shift_exec_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_cnt    (in_cnt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    typedef struct {
        logic [15:0] d;
        logic [2:0]  rd;
        logic        z;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   emitted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference shift computed from the op definitions with integer arithmetic
    function automatic exp_t refOp(input int op, input int a, input int c, input int rd);
        exp_t r;
        int   v;
        case (op)
            0: v = ((a << c) | (a >> (16 - c))) & 'hFFFF;
            1: v = (a << c) & 'hFFFF;
            2: v = ((a >> c) | (a << (16 - c))) & 'hFFFF;
            3: v = a >> c;
            4: v = (a >= 'h8000) ? (((a - 'h10000) >>> c) & 'hFFFF) : (a >> c);
            default: v = 0;
        endcase
        r.d  = v[15:0];
        r.rd = rd[2:0];
        r.z  = (v == 0);
        r.e  = (op > 4);
        return r;
    endfunction

    // One clock: check outputs against the model, then advance model across the edge
    task automatic cycle(output bit acc);
        bit   emt, fl;
        exp_t nxt;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_rd",   out_rd,   q[0].rd);
            chk("out_zero", out_zero, q[0].z);
            chk("out_err",  out_err,  q[0].e);
        end
        fl  = flush;
        acc = in_valid && (q.size() < 2) && !fl;
        emt = (q.size() > 0) && out_ready;
        nxt = refOp(int'(in_op), int'(in_a), int'(in_cnt), int'(in_rd));
        @(posedge clk);
        #1;
        if (emt) emitted++;
        if (fl) begin
            q.delete();
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(nxt);
        end
    endtask

    task automatic setIn(input bit v, input logic [2:0] op, input logic [15:0] a,
                         input logic [3:0] c, input logic [2:0] rd);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_cnt   = c;
        in_rd    = rd;
    endtask

    // Single op with immediate drain; checks the result one cycle after accept
    task automatic oneShot(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [3:0] c, input logic [15:0] expData, input logic expZero);
        bit acc;
        out_ready = 1'b1;
        setIn(1'b1, op, a, c, 3'd1);
        cycle(acc);
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"},  out_data,  expData);
        chk({tag, "_zero"},  out_zero,  expZero);
        cycle(acc);
    endtask

    initial begin
        bit acc;
        bit sawFull;
        int k;
        int startEmit;
        logic [2:0] opv;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        setIn(1'b0, 3'd0, 16'h0, 4'h0, 3'd0);
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_data",  out_data,  16'h0);
        chk("rst_out_rd",    out_rd,    3'd0);
        chk("rst_out_zero",  out_zero,  1'b1);
        chk("rst_out_err",   out_err,   1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1 / T2: directed edges
        oneShot("t1_ror",   3'd2, 16'h8001, 4'd1,  16'hC000, 1'b0);
        oneShot("t2_ror0",  3'd2, 16'h1234, 4'd0,  16'h1234, 1'b0);
        oneShot("t2_sra",   3'd4, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        oneShot("t2_srl",   3'd3, 16'h8000, 4'd15, 16'h0001, 1'b0);
        oneShot("t2_sll0",  3'd1, 16'h8000, 4'd1,  16'h0000, 1'b1);
        oneShot("t6_ill",   3'd7, 16'hFFFF, 4'd3,  16'h0000, 1'b1);
        chk("t6_ill_err_seen", q.size(), 0);

        // T3: 4 ops with out_ready low for the first 3 cycles
        out_ready = 1'b0;
        sawFull = 1'b0;
        k = 0;
        startEmit = emitted;
        for (int c = 0; c < 20 && k < 4; c++) begin
            out_ready = (c >= 3);
            setIn(1'b1, 3'(k % 5), 16'hA5C3 + 16'(k * 16'h0111), 4'(k + 3), 3'(k + 2));
            if (q.size() == 2) sawFull = 1'b1;
            cycle(acc);
            if (acc) k++;
        end
        chk("t3_all_accepted", k, 4);
        chk("t3_in_ready_dropped", sawFull, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) cycle(acc);
        chk("t3_emitted", emitted - startEmit, 4);

        // T4: full throughput
        startEmit = emitted;
        for (int c = 0; c < 8; c++) begin
            setIn(1'b1, 3'(c % 5), 16'($urandom), 4'($urandom), 3'(c));
            cycle(acc);
            chk("t4_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("t4_emitted", emitted - startEmit, 8);

        // T5: flush while FULL
        out_ready = 1'b0;
        setIn(1'b1, 3'd1, 16'h0F0F, 4'd2, 3'd3);
        cycle(acc);
        setIn(1'b1, 3'd3, 16'hF0F0, 4'd4, 3'd4);
        cycle(acc);
        chk("t5_full", q.size(), 2);
        flush = 1'b1;
        setIn(1'b1, 3'd0, 16'h1111, 4'd1, 3'd6);
        cycle(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_valid", out_valid, 1'b0);
        chk("t5_flush_ready", in_ready,  1'b1);
        setIn(1'b1, 3'd2, 16'h0003, 4'd1, 3'd5);
        cycle(acc);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t5_new_valid", out_valid, 1'b1);
        chk("t5_new_rd",    out_rd,    3'd5);
        chk("t5_new_data",  out_data,  16'h8001);
        cycle(acc);

        // Randomized mix against the model
        for (int c = 0; c < 300; c++) begin
            opv = ($urandom_range(0, 9) > 7) ? 3'd2 : 3'($urandom_range(0, 7));
            setIn($urandom_range(0, 3) != 0, opv, 16'($urandom), 4'($urandom), 3'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle(acc);
        end
        flush = 1'b0;

        // T6: async reset between edges with ops in flight
        out_ready = 1'b0;
        setIn(1'b1, 3'd0, 16'h00F0, 4'd4, 3'd7);
        cycle(acc);
        cycle(acc);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_in_ready",  in_ready,  1'b1);
        chk("t6_out_data",  out_data,  16'h0);
        chk("t6_out_rd",    out_rd,    3'd0);
        chk("t6_out_zero",  out_zero,  1'b1);
        chk("t6_out_err",   out_err,   1'b0);
        q.delete();
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        setIn(1'b1, 3'd4, 16'h8000, 4'd3, 3'd2);
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        cycle(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
